// File: rtl/pop_result_logger_pkg.sv
// ---------------------------------------------------------------------------
// pop_result_logger_pkg
// Shared types and width helpers for the PIFO pop-result logger.
//   - logger_state_e : run-control state (RUN / DRAIN / DONE)
//   - pop_record_t   : reference layout of one logged record at default widths
//   - id_bits()      : index width for N items, never narrower than 1 bit
//   - rec_width()    : width of a packed {ts, tree_id, priority, data} record
// ---------------------------------------------------------------------------
package pop_result_logger_pkg;

    localparam int DEF_PTW      = 16;
    localparam int DEF_MTW      = 16;
    localparam int DEF_TREE_NUM = 4;
    localparam int DEF_TS_W     = 32;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } logger_state_e;

    // A single logical tree still needs a 1-bit id field so the port exists.
    function automatic int id_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Payload carries metadata plus a copy of the priority, hence MTW+PTW.
    function automatic int rec_width(input int ts_w, input int tnb,
                                     input int ptw, input int mtw);
        return ts_w + tnb + ptw + (mtw + ptw);
    endfunction

    localparam int DEF_TREE_NUM_BITS = id_bits(DEF_TREE_NUM);
    localparam int REC_W = rec_width(DEF_TS_W, DEF_TREE_NUM_BITS, DEF_PTW, DEF_MTW);

    typedef struct packed {
        logic [DEF_TS_W-1:0]          ts;
        logic [DEF_TREE_NUM_BITS-1:0] tree_id;
        logic [DEF_PTW-1:0]           prio;
        logic [DEF_MTW+DEF_PTW-1:0]   data;
    } pop_record_t;

endpackage

// File: rtl/pop_result_logger_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Show-ahead single-clock FIFO. The head entry is always visible on o_head.
// A push while full is accepted when a pop happens in the same cycle
// (read-before-write), leaving occupancy unchanged.
// Ports:
//   i_clk, i_arst_n : clock, async active-low reset (pointers only)
//   i_push, i_data  : write request and data
//   i_pop           : advance head (ignored when empty)
//   o_full, o_empty : status
//   o_head          : current head entry (undefined content when empty)
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_arst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_head    = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_do_pop)  r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    // Storage is data only; validity is tracked entirely by the pointers.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/pop_result_logger.sv
// ---------------------------------------------------------------------------
// pop_result_logger
// Timestamps PIFO pop results, buffers them in a small FIFO and drains them to
// a result-RAM write port with backpressure. Keeps push/pop/return statistics
// and declares end-of-run after the trace finishes and every issued pop is
// accounted for (logged or dropped), or when the drain timeout expires.
// Ports:
//   i_clk, i_arst_n          : clock, async active-low reset
//   i_push, i_pop            : operations issued to the PIFO tree
//   i_trace_finish           : trace stimulus exhausted
//   i_pop_valid/_priority/_tree_id/_data : pop result from the tree
//   o_wr_en, i_wr_ready      : result RAM write handshake
//   o_wr_addr, o_wr_data     : RAM address and record {ts, tree_id, prio, data}
//   o_push_cnt, o_pop_cnt, o_ret_cnt : saturating statistics
//   o_overflow, o_timeout, o_done    : sticky status flags
// ---------------------------------------------------------------------------
module pop_result_logger
    import pop_result_logger_pkg::*;
#(
    parameter int PTW           = 16,
    parameter int MTW           = 16,
    parameter int TREE_NUM      = 4,
    parameter int FIFO_DEPTH    = 8,
    parameter int LOG_SIZE      = 1024,
    parameter int TS_W          = 32,
    parameter int CNT_W         = 32,
    parameter int DRAIN_TIMEOUT = 4096,
    localparam int TREE_NUM_BITS = id_bits(TREE_NUM),
    localparam int LOG_ADDR_W    = id_bits(LOG_SIZE),
    localparam int REC_W_L       = rec_width(TS_W, TREE_NUM_BITS, PTW, MTW)
) (
    input  logic                     i_clk,
    input  logic                     i_arst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_trace_finish,
    input  logic                     i_pop_valid,
    input  logic [PTW-1:0]           i_pop_priority,
    input  logic [TREE_NUM_BITS-1:0] i_pop_tree_id,
    input  logic [MTW+PTW-1:0]       i_pop_data,
    output logic                     o_wr_en,
    input  logic                     i_wr_ready,
    output logic [LOG_ADDR_W-1:0]    o_wr_addr,
    output logic [REC_W_L-1:0]       o_wr_data,
    output logic [CNT_W-1:0]         o_push_cnt,
    output logic [CNT_W-1:0]         o_pop_cnt,
    output logic [CNT_W-1:0]         o_ret_cnt,
    output logic                     o_overflow,
    output logic                     o_timeout,
    output logic                     o_done
);

    localparam int TO_W = $clog2(DRAIN_TIMEOUT + 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [TS_W-1:0]       r_ts;
    logic [LOG_ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]      r_push_cnt;
    logic [CNT_W-1:0]      r_pop_cnt;
    logic [CNT_W-1:0]      r_ret_cnt;
    logic [CNT_W-1:0]      r_drop_cnt;
    logic                  r_overflow;
    logic                  r_timeout;
    logic                  r_done;
    logic [TO_W-1:0]       r_timer;
    logger_state_e         r_state;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_drain;
    logic                  w_accept;
    logic                  w_drop;
    logic [REC_W_L-1:0]    w_rec;
    logic [REC_W_L-1:0]    w_head;
    logic [CNT_W:0]        w_returned;
    logic                  w_all_back;
    logic [TO_W-1:0]       w_timer_nxt;

    // Record takes the timestamp of the cycle the result is presented.
    assign w_rec    = {r_ts, i_pop_tree_id, i_pop_priority, i_pop_data};
    assign w_drain  = !w_empty && i_wr_ready;
    assign w_accept = i_pop_valid && (!w_full || w_drain);
    assign w_drop   = i_pop_valid && w_full && !w_drain;

    sync_fifo #(
        .WIDTH (REC_W_L),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk    (i_clk),
        .i_arst_n (i_arst_n),
        .i_push   (w_accept),
        .i_data   (w_rec),
        .i_pop    (i_wr_ready),
        .o_full   (w_full),
        .o_empty  (w_empty),
        .o_head   (w_head)
    );

    // Stale storage is masked so the write port reads zero whenever idle.
    assign o_wr_en    = !w_empty;
    assign o_wr_data  = w_empty ? '0 : w_head;
    assign o_wr_addr  = r_addr;
    assign o_push_cnt = r_push_cnt;
    assign o_pop_cnt  = r_pop_cnt;
    assign o_ret_cnt  = r_ret_cnt;
    assign o_overflow = r_overflow;
    assign o_timeout  = r_timeout;
    assign o_done     = r_done;

    // One extra bit so the sum of returned + dropped cannot wrap.
    assign w_returned  = {1'b0, r_ret_cnt} + {1'b0, r_drop_cnt};
    assign w_all_back  = (w_returned == {1'b0, r_pop_cnt}) && w_empty;
    assign w_timer_nxt = r_timer + TO_W'(1);

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_ts       <= '0;
            r_addr     <= '0;
            r_push_cnt <= '0;
            r_pop_cnt  <= '0;
            r_ret_cnt  <= '0;
            r_drop_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_ts <= r_ts + TS_W'(1);
            if (w_drain)  r_addr     <= r_addr + LOG_ADDR_W'(1);
            if (i_push)   r_push_cnt <= sat_inc(r_push_cnt);
            if (i_pop)    r_pop_cnt  <= sat_inc(r_pop_cnt);
            if (w_accept) r_ret_cnt  <= sat_inc(r_ret_cnt);
            if (w_drop) begin
                r_drop_cnt <= sat_inc(r_drop_cnt);
                r_overflow <= 1'b1;
            end
        end
    end

    // Run control. The normal exit is tested first so it wins a tie with the
    // timeout.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_state   <= ST_RUN;
            r_timer   <= '0;
            r_timeout <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (i_trace_finish) begin
                        r_state <= ST_DRAIN;
                        r_timer <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (w_all_back) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else if (w_timer_nxt == TO_W'(DRAIN_TIMEOUT)) begin
                        r_state   <= ST_DONE;
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                    end else begin
                        r_timer <= w_timer_nxt;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

endmodule

// File: doc/pop_result_logger.md
Name: pop_result_logger

Overview:
- Sits directly downstream of the PIFO tree, alongside the trace-driven stimulus stage.
- Timestamps every pop result returned by the PIFO tree and buffers it in a small FIFO.
- Drains the FIFO to a result-RAM write port that can apply backpressure.
- Counts issued pushes, issued pops and returned pops, and declares end-of-run once the trace finishes and all outstanding pops are logged or a drain timeout expires.

Parameters:
- PTW, 16, priority/payload width
- MTW, 16, metadata width
- TREE_NUM, 4, number of logical PIFO trees; TREE_NUM_BITS = $clog2(TREE_NUM)
- FIFO_DEPTH, 8, result FIFO entries; power of 2, >= 2
- LOG_SIZE, 1024, result RAM entries; power of 2; LOG_ADDR_W = $clog2(LOG_SIZE)
- TS_W, 32, timestamp width
- CNT_W, 32, statistics counter width
- DRAIN_TIMEOUT, 4096, max cycles spent in DRAIN; TO_W = $clog2(DRAIN_TIMEOUT+1)
- Derived: REC_W = TS_W + TREE_NUM_BITS + PTW + (MTW+PTW)

Ports:
- i_clk  in  1  clock
- i_arst_n  in  1  async active-low reset
- i_push  in  1  push issued to PIFO tree this cycle
- i_pop  in  1  pop issued to PIFO tree this cycle
- i_trace_finish  in  1  trace stimulus exhausted (level or pulse)
- i_pop_valid  in  1  PIFO pop result valid
- i_pop_priority  in  PTW  result priority
- i_pop_tree_id  in  TREE_NUM_BITS  result tree id
- i_pop_data  in  MTW+PTW  result payload
- o_wr_en  out  1  result RAM write request
- i_wr_ready  in  1  RAM accepts the write this cycle
- o_wr_addr  out  LOG_ADDR_W  result RAM address
- o_wr_data  out  REC_W  record {ts, tree_id, priority, data}
- o_push_cnt  out  CNT_W  pushes seen
- o_pop_cnt  out  CNT_W  pops issued
- o_ret_cnt  out  CNT_W  pop results accepted into FIFO
- o_overflow  out  1  sticky: a result was dropped
- o_timeout  out  1  sticky: DRAIN ended by timeout
- o_done  out  1  sticky: run complete

Behaviour:
- Reset (async, active-low): all outputs 0, FIFO empty, timestamp 0, state RUN.
- Timestamp: free-running, +1 per cycle, wraps at 2^TS_W.
  - A record captures the timestamp value of the cycle in which i_pop_valid is high.
- FIFO write: when i_pop_valid && (!full || drain_this_cycle).
  - Full with a simultaneous drain: the write is accepted and occupancy is unchanged.
  - Full with no drain: the result is dropped, o_overflow is set (sticky), o_ret_cnt does not increment.
- FIFO read (show-ahead): o_wr_en = !empty; o_wr_data = head entry.
  - The head advances when o_wr_en && i_wr_ready.
  - o_wr_en and o_wr_data hold stable while i_wr_ready = 0.
- Latency: i_pop_valid at cycle t into an empty FIFO gives o_wr_en = 1 at cycle t+1.
- o_wr_addr: +1 per accepted write, wraps LOG_SIZE-1 -> 0.
- Counters: +1 on i_push, i_pop and accepted result respectively.
  - Counters saturate at all-ones.
  - i_push and i_pop may both be high in one cycle; both counters count.
- State machine:
  - RUN -> DRAIN on i_trace_finish; the drain timer is cleared.
  - DRAIN: timer +1 per cycle.
    - -> DONE when (o_ret_cnt + dropped count == o_pop_cnt) and FIFO empty.
    - Otherwise -> DONE when the timer reaches DRAIN_TIMEOUT; o_timeout is set in the same cycle.
    - If both conditions hold in the same cycle, the normal exit wins and o_timeout stays 0.
  - DONE: o_done = 1, sticky until reset.
    - Counters and the FIFO keep operating; late results are still logged.
- Dropped count is an internal CNT_W counter, saturating.
- i_trace_finish in DRAIN or DONE is ignored.
- Reset asserted mid-operation clears all state immediately; FIFO contents are lost.

Decomposition:
- Shared package:
  - pop_record_t struct {ts, tree_id, priority, data}
  - logger_state_e {RUN, DRAIN, DONE}
  - REC_W and width helper functions
- One sub-module: sync_fifo, parameterised by WIDTH and DEPTH.
  - Ports: push, pop, full, empty, head.
  - Read-before-write allowed when full.

Test Plan:
- Single result: i_pop=1 at t0, i_pop_valid=1 at t2 with priority 5, tree 2, data 0xAB; i_wr_ready=1 -> o_wr_en=1 at t3, o_wr_data={ts=2, 2, 5, 0xAB}, o_wr_addr=0, then 1.
- Backpressure: i_wr_ready=0, 9 back-to-back results with FIFO_DEPTH=8 -> 8 accepted, o_overflow=1, o_ret_cnt=8, first record held stable until ready.
- Full with simultaneous drain: FIFO full, i_wr_ready=1, i_pop_valid=1 -> no drop, occupancy stays 8, o_overflow=0.
- Normal end: 3 pops issued, i_trace_finish, 3 results returned and drained -> o_done=1 one cycle after FIFO empty, o_timeout=0.
- Timeout: 2 pops issued, 1 result returned, i_trace_finish, DRAIN_TIMEOUT=16 -> o_done=1 and o_timeout=1 16 cycles after entering DRAIN.
- Address wrap and reset: LOG_SIZE=4, 5 writes -> 5th write at address 0; assert i_arst_n=0 mid-stream -> all outputs 0 asynchronously.
